// File: rtl/clock_pkg.sv
// Shared state encoding, BCD limits and digit-legality helpers for the
// HH.MM time-of-day counter.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2
   } state_t;

   localparam logic [3:0] MAX_MIN_TENS    = 4'd5;
   localparam logic [3:0] MAX_HOUR_TENS   = 4'd2;
   localparam logic [3:0] HOUR_WRAP_UNITS = 4'd3;

   function automatic logic min_valid(input logic [3:0] tens, input logic [3:0] units);
      return (tens <= MAX_MIN_TENS) && (units <= 4'd9);
   endfunction

   function automatic logic hour_valid(input logic [3:0] tens, input logic [3:0] units);
      return ((tens < MAX_HOUR_TENS) && (units <= 4'd9)) ||
             ((tens == MAX_HOUR_TENS) && (units <= HOUR_WRAP_UNITS));
   endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD 00..59 counter used for seconds and minutes; carry is
// combinational so the next field can advance on the same edge.
module bcd_mod60_counter
   import clock_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       carry
);

   logic [3:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;

   assign tens  = tens_q;
   assign units = units_q;
   assign carry = inc && (tens_q == MAX_MIN_TENS) && (units_q == 4'd9);

   // Next value: any out-of-range digit pair collapses to 00.
   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (clr || !min_valid(tens_q, units_q)) begin
         tens_d  = 4'd0;
         units_d = 4'd0;
      end else if (inc) begin
         if (units_q == 4'd9) begin
            units_d = 4'd0;
            tens_d  = (tens_q == MAX_MIN_TENS) ? 4'd0 : tens_q + 4'd1;
         end else begin
            units_d = units_q + 4'd1;
         end
      end else begin
         tens_d  = tens_q;
         units_d = units_q;
      end
   end

   // Digit registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tens_q  <= 4'd0;
         units_q <= 4'd0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH.MM BCD time-of-day counter with a 1 Hz prescaler and a
// two-button set mode (mode steps RUN -> SET_HOUR -> SET_MIN -> RUN).
module bcd_time_counter
   import clock_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000,
   parameter int DIV_W   = 26
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [3:0] numcount4_out,
   output logic [3:0] numcount3_out,
   output logic [3:0] numcount2_out,
   output logic [3:0] numcount1_out,
   output logic       sec_pulse,
   output logic       set_hour,
   output logic       set_min
);

   state_t           state_q;
   logic             key_mode_q, key_inc_q;
   logic             mode_ev, inc_ev, run, tick;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [3:0]       hour_tens_q, hour_tens_d, hour_units_q, hour_units_d;
   logic [3:0]       sec_tens, sec_units;
   logic             sec_carry, min_carry, min_inc, hour_inc, unused_sec;

   assign mode_ev    = key_mode & ~key_mode_q;
   assign inc_ev     = key_inc & ~key_inc_q;
   assign run        = (state_q == ST_RUN);
   // A mode step in RUN takes precedence over a coinciding tick.
   assign tick       = run && !mode_ev && (div_cnt_q == DIV_W'(CLK_DIV - 1));
   assign min_inc    = (run && sec_carry) ||
                       ((state_q == ST_SET_MIN) && inc_ev && !mode_ev);
   assign hour_inc   = (run && min_carry) ||
                       ((state_q == ST_SET_HOUR) && inc_ev && !mode_ev);
   assign unused_sec = ^{sec_tens, sec_units};

   assign numcount4_out = hour_tens_q;
   assign numcount3_out = hour_units_q;

   // Key history; follows the levels even during reset.
   always_ff @(posedge clk) begin
      key_mode_q <= key_mode;
      key_inc_q  <= key_inc;
   end

   // Mode FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         set_hour  <= 1'b0;
         set_min   <= 1'b0;
         sec_pulse <= 1'b0;
      end else begin
         sec_pulse <= tick;
         case (state_q)
            ST_RUN: begin
               if (mode_ev) begin
                  state_q  <= ST_SET_HOUR;
                  set_hour <= 1'b1;
               end else begin
                  set_hour <= 1'b0;
               end
               set_min <= 1'b0;
            end
            ST_SET_HOUR: begin
               if (mode_ev) begin
                  state_q  <= ST_SET_MIN;
                  set_hour <= 1'b0;
                  set_min  <= 1'b1;
               end else begin
                  set_hour <= 1'b1;
                  set_min  <= 1'b0;
               end
            end
            ST_SET_MIN: begin
               if (mode_ev) begin
                  state_q <= ST_RUN;
                  set_min <= 1'b0;
               end else begin
                  set_min <= 1'b1;
               end
               set_hour <= 1'b0;
            end
            default: begin
               state_q  <= ST_RUN;
               set_hour <= 1'b0;
               set_min  <= 1'b0;
            end
         endcase
      end
   end

   // Prescaler is held at 0 outside RUN and restarts on any mode step.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (!run || mode_ev) begin
         div_cnt_d = '0;
      end else if (div_cnt_q >= DIV_W'(CLK_DIV - 1)) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   bcd_mod60_counter u_sec (
      .clk   (clk),
      .rst   (rst),
      .clr   (!run || mode_ev),
      .inc   (tick),
      .tens  (sec_tens),
      .units (sec_units),
      .carry (sec_carry)
   );

   bcd_mod60_counter u_min (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (min_inc),
      .tens  (numcount2_out),
      .units (numcount1_out),
      .carry (min_carry)
   );

   // Hours wrap at 23 rather than at a digit boundary, so they stay inline.
   always_comb begin
      hour_tens_d  = hour_tens_q;
      hour_units_d = hour_units_q;
      if (!hour_valid(hour_tens_q, hour_units_q)) begin
         hour_tens_d  = 4'd0;
         hour_units_d = 4'd0;
      end else if (hour_inc) begin
         if ((hour_tens_q == MAX_HOUR_TENS) && (hour_units_q == HOUR_WRAP_UNITS)) begin
            hour_tens_d  = 4'd0;
            hour_units_d = 4'd0;
         end else if (hour_units_q == 4'd9) begin
            hour_tens_d  = hour_tens_q + 4'd1;
            hour_units_d = 4'd0;
         end else begin
            hour_units_d = hour_units_q + 4'd1;
         end
      end else begin
         hour_tens_d  = hour_tens_q;
         hour_units_d = hour_units_q;
      end
   end

   // Hour digit registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hour_tens_q  <= 4'd0;
         hour_units_q <= 4'd0;
      end else begin
         hour_tens_q  <= hour_tens_d;
         hour_units_q <= hour_units_d;
      end
   end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench: a time-of-day model (seconds-of-day arithmetic) predicts
// every cycle's outputs; a separate monitor compares them after each edge.
module tb_bcd_time_counter;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_mode = 1'b0;
   logic       key_inc = 1'b0;
   logic [3:0] n4, n3, n2, n1;
   logic       sec_pulse, set_hour, set_min;

   typedef struct {
      logic [15:0] digits;
      logic        pulse;
      logic        sh;
      logic        sm;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state
   int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_div = 0;
   int m_pkm = 0, m_pki = 0, m_pulse = 0;

   bcd_time_counter #(.CLK_DIV(CLK_DIV), .DIV_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .key_mode      (key_mode),
      .key_inc       (key_inc),
      .numcount4_out (n4),
      .numcount3_out (n3),
      .numcount2_out (n2),
      .numcount1_out (n1),
      .sec_pulse     (sec_pulse),
      .set_hour      (set_hour),
      .set_min       (set_min)
   );

   always #5 clk = ~clk;

   function automatic void model_step(input int r, input int km, input int ki);
      int mev, iev, t;
      if (r != 0) begin
         m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_div = 0; m_pulse = 0;
         m_pkm = km; m_pki = ki;
         return;
      end
      mev = (km != 0 && m_pkm == 0) ? 1 : 0;
      iev = (ki != 0 && m_pki == 0) ? 1 : 0;
      m_pkm = km; m_pki = ki;
      m_pulse = 0;
      if (m_mode == 0) begin
         if (mev != 0) begin
            m_mode = 1; m_s = 0; m_div = 0;
         end else if (m_div == CLK_DIV - 1) begin
            m_div = 0; m_pulse = 1;
            t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
         end else begin
            m_div = m_div + 1;
         end
      end else if (m_mode == 1) begin
         if (mev != 0) m_mode = 2;
         else if (iev != 0) m_h = (m_h + 1) % 24;
      end else begin
         if (mev != 0) begin
            m_mode = 0; m_div = 0;
         end else if (iev != 0) m_m = (m_m + 1) % 60;
      end
   endfunction

   task automatic cycle(input logic r, input logic km, input logic ki);
      exp_t e;
      @(negedge clk);
      rst = r; key_mode = km; key_inc = ki;
      model_step(int'(r), int'(km), int'(ki));
      e.digits = {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10)};
      e.pulse  = (m_pulse != 0);
      e.sh     = (m_mode == 1);
      e.sm     = (m_mode == 2);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_mode();
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         cycle(1'b0, 1'b0, 1'b0);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output word.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if ({n4, n3, n2, n1} !== e.digits) begin
               fails++;
               $display("FAIL digits: got %h expected %h at %0t", {n4, n3, n2, n1}, e.digits, $time);
            end
            tests++;
            if (sec_pulse !== e.pulse) begin
               fails++;
               $display("FAIL sec_pulse: got %b expected %b at %0t", sec_pulse, e.pulse, $time);
            end
            tests++;
            if ({set_hour, set_min} !== {e.sh, e.sm}) begin
               fails++;
               $display("FAIL set_flags: got %b%b expected %b%b at %0t", set_hour, set_min, e.sh, e.sm, $time);
            end
         end
      end
   end

   initial begin
      logic km, ki, r;
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      idle(240);                       // 60 seconds -> 00.01
      press_mode(); press_inc(23);     // hours 23
      press_mode(); press_inc(58);     // minutes 59
      press_mode(); idle(245);         // 23:59:59 -> 00:00:00
      press_mode(); press_inc(5);
      press_mode(); press_inc(61);
      press_mode(); idle(10);          // first pulse CLK_DIV cycles after RUN
      press_mode(); press_inc(18); press_inc(1);
      press_mode(); press_inc((59 - m_m + 60) % 60); press_inc(1);
      press_mode(); idle(5);
      cycle(1'b0, 1'b1, 1'b1);         // simultaneous edges: mode wins
      cycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      press_mode(); press_mode(); idle(6);
      press_mode(); press_inc((12 - m_h + 24) % 24);
      press_mode(); press_inc((34 - m_m + 60) % 60);
      cycle(1'b1, 1'b1, 1'b0);         // reset with key_mode held
      cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
      idle(8);
      km = 1'b0; ki = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) km = ~km;
         if ($urandom_range(0, 3) == 0) ki = ~ki;
         r = ($urandom_range(0, 499) == 0);
         cycle(r, km, ki);
      end
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
